// File: rtl/factor_game_pkg.sv
// Shared constants for the factorization quiz controller.
//   - 4-bit state codes presented to the 7-seg decoder, wrapped in a typed enum
//   - LFSR seed and feedback tap mask
//   - spf(): smallest prime factor of a question digit (0 and 1 map to 0)
package factor_game_pkg;

   localparam logic [3:0] CodeIdle     = 4'b0001;
   localparam logic [3:0] CodeReady    = 4'b0010;
   localparam logic [3:0] CodeQuestion = 4'b0011;
   localparam logic [3:0] CodeInput    = 4'b0100;
   localparam logic [3:0] CodeDone     = 4'b0110;
   localparam logic [3:0] CodeCorrect  = 4'b0111;
   localparam logic [3:0] CodeWrong    = 4'b1000;

   typedef enum logic [3:0] {
      StIdle     = CodeIdle,
      StReady    = CodeReady,
      StQuestion = CodeQuestion,
      StInput    = CodeInput,
      StDone     = CodeDone,
      StCorrect  = CodeCorrect,
      StWrong    = CodeWrong
   } game_state_e;

   localparam logic [7:0] LfsrSeed = 8'hA5;
   // Feedback = l[7] ^ l[5] ^ l[4] ^ l[3]
   localparam logic [7:0] LfsrTaps = 8'b1011_1000;

   function automatic logic [3:0] spf(input logic [3:0] digit);
      logic [3:0] f;
      case (digit)
         4'd2, 4'd4, 4'd6, 4'd8: f = 4'd2;
         4'd3, 4'd9:             f = 4'd3;
         4'd5:                   f = 4'd5;
         4'd7:                   f = 4'd7;
         default:                f = 4'd0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/key_edge.sv
// Push-button conditioner: 2-flop synchronizer followed by a falling-edge
// detector, giving one single-cycle pulse per press of an active-low key.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset; all flops reset to "released" (1)
//   key_ni   raw active-low key, asynchronous to clk_i
//   press_o  1-cycle pulse on each synced 1->0 transition
module key_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_ni,
   output logic press_o
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= key_ni;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/factor_game_ctrl.sv
// Game-control FSM for the factorization quiz. Draws a pseudo-random digit
// from an 8-bit LFSR, shows it, collects the switch answer, judges it against
// the digit's smallest prime factor and keeps score/round counts.
// Ports:
//   CLK, nRST          clock, synchronous active-low reset
//   nKEY_START/ENTER   active-low push-buttons (asynchronous)
//   SW[3:0]            answer switches (asynchronous)
//   STATE[3:0]         state code to the display decoder
//   QUE[3:0]           question digit 0..9
//   DIN[3:0]           registered answer value
//   SCORE[3:0]         correct answers this game, saturating at 15
//   ROUND[3:0]         completed rounds this game
//   BUSY               high in every state except IDLE and DONE
module factor_game_ctrl
   import factor_game_pkg::*;
#(
   parameter int unsigned READY_TICKS  = 50_000_000,
   parameter int unsigned QUE_TICKS    = 100_000_000,
   parameter int unsigned INPUT_TICKS  = 500_000_000,
   parameter int unsigned RESULT_TICKS = 50_000_000,
   parameter int unsigned ROUNDS       = 5
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       nKEY_START,
   input  logic       nKEY_ENTER,
   input  logic [3:0] SW,
   output logic [3:0] STATE,
   output logic [3:0] QUE,
   output logic [3:0] DIN,
   output logic [3:0] SCORE,
   output logic [3:0] ROUND,
   output logic       BUSY
);

   localparam logic [3:0] RoundsCode = 4'(ROUNDS);

   logic        start_p, enter_p;
   logic [3:0]  sw_meta_q, sw_sync_q;
   logic [7:0]  lfsr_q;
   logic [31:0] timer_q;
   game_state_e state_q;
   logic [3:0]  que_q, din_q, score_q, round_q;
   logic        busy_q;

   logic [3:0]  lfsr_nib, next_que, score_inc, round_inc;

   key_edge u_key_start (
      .clk_i  (CLK),
      .rst_ni (nRST),
      .key_ni (nKEY_START),
      .press_o(start_p)
   );

   key_edge u_key_enter (
      .clk_i  (CLK),
      .rst_ni (nRST),
      .key_ni (nKEY_ENTER),
      .press_o(enter_p)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         sw_meta_q <= 4'd0;
         sw_sync_q <= 4'd0;
      end else begin
         sw_meta_q <= SW;
         sw_sync_q <= sw_meta_q;
      end
   end

   // Fold the low nibble into 0..9 so QUE is always a single decimal digit.
   assign lfsr_nib  = lfsr_q[3:0];
   assign next_que  = (lfsr_nib >= 4'd10) ? (lfsr_nib - 4'd10) : lfsr_nib;
   assign score_inc = (score_q == 4'hF) ? 4'hF : (score_q + 4'd1);
   assign round_inc = round_q + 4'd1;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StIdle;
         timer_q <= 32'd0;
         lfsr_q  <= LfsrSeed;
         que_q   <= 4'd0;
         din_q   <= 4'd0;
         score_q <= 4'd0;
         round_q <= 4'd0;
         busy_q  <= 1'b0;
      end else begin
         lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
         case (state_q)
            StIdle, StDone: begin
               if (start_p) begin
                  state_q <= StReady;
                  timer_q <= 32'd0;
                  score_q <= 4'd0;
                  round_q <= 4'd0;
                  busy_q  <= 1'b1;
               end
            end
            StReady: begin
               if (timer_q == READY_TICKS - 1) begin
                  state_q <= StQuestion;
                  timer_q <= 32'd0;
                  que_q   <= next_que;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            StQuestion: begin
               if (timer_q == QUE_TICKS - 1) begin
                  state_q <= StInput;
                  timer_q <= 32'd0;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            StInput: begin
               din_q <= sw_sync_q;
               // ENTER wins over a timeout landing on the same cycle.
               if (enter_p) begin
                  timer_q <= 32'd0;
                  if (sw_sync_q == spf(que_q)) begin
                     state_q <= StCorrect;
                     score_q <= score_inc;
                  end else begin
                     state_q <= StWrong;
                  end
               end else if (timer_q == INPUT_TICKS - 1) begin
                  state_q <= StWrong;
                  timer_q <= 32'd0;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            StCorrect, StWrong: begin
               if (timer_q == RESULT_TICKS - 1) begin
                  timer_q <= 32'd0;
                  round_q <= round_inc;
                  if (round_inc == RoundsCode) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= StReady;
                  end
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               timer_q <= 32'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign STATE = state_q;
   assign QUE   = que_q;
   assign DIN   = din_q;
   assign SCORE = score_q;
   assign ROUND = round_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_factor_game_ctrl.sv
// Bench for factor_game_ctrl: directed phase table, hand-written corner
// sequences and a randomized phase, all shadowed by a cycle-level game model.
module tb_factor_game_ctrl;

   localparam int ReadyT  = 4;
   localparam int QueT    = 8;
   localparam int InputT  = 32;
   localparam int ResultT = 4;
   localparam int Rounds  = 3;

   localparam logic [3:0] SIdle = 4'b0001, SReady = 4'b0010, SQuest = 4'b0011,
                          SInput = 4'b0100, SDone = 4'b0110, SCorr = 4'b0111,
                          SWrong = 4'b1000;

   logic       CLK = 1'b0;
   logic       n_rst = 1'b0, n_start = 1'b1, n_enter = 1'b1;
   logic [3:0] sw = 4'd0;
   logic [3:0] STATE, QUE, DIN, SCORE, ROUND;
   logic       BUSY;

   int n_tests = 0;
   int n_fails = 0;
   int cyc = 0;

   factor_game_ctrl #(
      .READY_TICKS (ReadyT),
      .QUE_TICKS   (QueT),
      .INPUT_TICKS (InputT),
      .RESULT_TICKS(ResultT),
      .ROUNDS      (Rounds)
   ) dut (
      .CLK       (CLK),
      .nRST      (n_rst),
      .nKEY_START(n_start),
      .nKEY_ENTER(n_enter),
      .SW        (sw),
      .STATE     (STATE),
      .QUE       (QUE),
      .DIN       (DIN),
      .SCORE     (SCORE),
      .ROUND     (ROUND),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   int         spf_tab [0:9] = '{0, 0, 2, 3, 2, 5, 2, 7, 2, 3};
   logic [3:0] m_state = SIdle;
   logic [3:0] m_que = 0, m_din = 0, m_score = 0, m_round = 0;
   logic [7:0] m_lfsr = 8'hA5;
   int         m_cnt = 0;
   // Raw key/switch values seen at the previous 1..3 edges (index 0 = newest).
   logic       hs [0:2] = '{1'b1, 1'b1, 1'b1};
   logic       he [0:2] = '{1'b1, 1'b1, 1'b1};
   logic [3:0] hsw[0:1] = '{4'd0, 4'd0};

   function automatic logic [3:0] spf_ref(input logic [3:0] q);
      return (q < 10) ? 4'(spf_tab[q]) : 4'd0;
   endfunction

   function automatic logic m_busy();
      return !(m_state == SIdle || m_state == SDone);
   endfunction

   task automatic model_step();
      logic       ps, pe;
      logic [3:0] swv, digit;
      if (!n_rst) begin
         m_state = SIdle; m_que = 0; m_din = 0; m_score = 0; m_round = 0;
         m_cnt = 0; m_lfsr = 8'hA5;
         hs = '{1'b1, 1'b1, 1'b1}; he = '{1'b1, 1'b1, 1'b1}; hsw = '{4'd0, 4'd0};
      end else begin
         // A key counts as pressed at this edge if it was low 2 edges ago
         // and high 3 edges ago (synchronizer latency).
         ps    = !hs[1] && hs[2];
         pe    = !he[1] && he[2];
         swv   = hsw[1];
         digit = m_lfsr[3:0] % 10;
         m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         case (m_state)
            SIdle, SDone: if (ps) begin
               m_state = SReady; m_cnt = 0; m_score = 0; m_round = 0;
            end
            SReady: begin
               m_cnt++;
               if (m_cnt == ReadyT) begin m_state = SQuest; m_que = digit; m_cnt = 0; end
            end
            SQuest: begin
               m_cnt++;
               if (m_cnt == QueT) begin m_state = SInput; m_cnt = 0; end
            end
            SInput: begin
               m_din = swv;
               m_cnt++;
               if (pe) begin
                  m_cnt = 0;
                  if (swv == spf_ref(m_que)) begin
                     m_state = SCorr;
                     if (m_score != 15) m_score++;
                  end else m_state = SWrong;
               end else if (m_cnt == InputT) begin
                  m_state = SWrong; m_cnt = 0;
               end
            end
            SCorr, SWrong: begin
               m_cnt++;
               if (m_cnt == ResultT) begin
                  m_cnt = 0;
                  m_round++;
                  m_state = (m_round == Rounds) ? SDone : SReady;
               end
            end
            default: m_state = SIdle;
         endcase
         hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = n_start;
         he[2] = he[1]; he[1] = he[0]; he[0] = n_enter;
         hsw[1] = hsw[0]; hsw[0] = sw;
      end
   endtask

   // One clock: model follows the edge, outputs compared mid-cycle.
   task automatic tick();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      cyc++;
      n_tests++;
      if (STATE !== m_state || QUE !== m_que || DIN !== m_din || SCORE !== m_score ||
          ROUND !== m_round || BUSY !== m_busy() || QUE > 4'd9) begin
         n_fails++;
         $display("FAIL lockstep cyc=%0d got st=%b que=%0d din=%0d sc=%0d rd=%0d busy=%b req st=%b que=%0d din=%0d sc=%0d rd=%0d busy=%b",
                  cyc, STATE, QUE, DIN, SCORE, ROUND, BUSY,
                  m_state, m_que, m_din, m_score, m_round, m_busy());
      end
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fails++;
         $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
      end
   endtask

   task automatic wait_state(input logic [3:0] code, input int budget);
      int n = 0;
      while (STATE !== code && n < budget) begin tick(); n++; end
      check("wait_state", int'(STATE), int'(code));
   endtask

   // ---------------- directed phase table ----------------
   typedef struct {
      logic       n_rst;
      logic       n_start;
      logic       n_enter;
      logic [3:0] sw;
      int         cycles;
      logic [3:0] st;
      int         score;
      int         round;
      logic       busy;
   } vec_t;

   vec_t vq[$];

   initial begin
      vq.push_back('{1'b0, 1'b1, 1'b1, 4'd0,    2, SIdle,  0, 0, 1'b0}); // reset
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd0,  100, SIdle,  0, 0, 1'b0}); // idle, no keys
      vq.push_back('{1'b1, 1'b0, 1'b1, 4'd0,   20, SInput, 0, 0, 1'b1}); // START held 20
      vq.push_back('{1'b1, 1'b1, 1'b0, 4'd15,   5, SWrong, 0, 0, 1'b1}); // wrong answer
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,   2, SReady, 0, 1, 1'b1});
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,   4, SQuest, 0, 1, 1'b1});
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,   8, SInput, 0, 1, 1'b1});
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,  32, SWrong, 0, 1, 1'b1}); // timeout
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,   4, SReady, 0, 2, 1'b1});
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,  12, SInput, 0, 2, 1'b1});
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,  29, SInput, 0, 2, 1'b1});
      vq.push_back('{1'b1, 1'b1, 1'b0, 4'd15,   3, SWrong, 0, 2, 1'b1}); // ENTER on cycle 32
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,   4, SDone,  0, 3, 1'b0});
      vq.push_back('{1'b1, 1'b0, 1'b1, 4'd15,   3, SReady, 0, 0, 1'b1}); // restart from DONE
      vq.push_back('{1'b1, 1'b1, 1'b0, 4'd15,   6, SQuest, 0, 0, 1'b1}); // ENTER in READY
      vq.push_back('{1'b0, 1'b1, 1'b1, 4'd15,   1, SIdle,  0, 0, 1'b0}); // reset in QUESTION
      vq.push_back('{1'b1, 1'b1, 1'b1, 4'd15,   3, SIdle,  0, 0, 1'b0});

      foreach (vq[i]) begin
         n_rst   = vq[i].n_rst;
         n_start = vq[i].n_start;
         n_enter = vq[i].n_enter;
         sw      = vq[i].sw;
         repeat (vq[i].cycles) tick();
         check($sformatf("vec%0d_state", i), int'(STATE), int'(vq[i].st));
         check($sformatf("vec%0d_score", i), int'(SCORE), vq[i].score);
         check($sformatf("vec%0d_round", i), int'(ROUND), vq[i].round);
         check($sformatf("vec%0d_busy", i), int'(BUSY), int'(vq[i].busy));
      end

      // ---------------- hand sequences ----------------
      // Round 1: correct answer.
      n_start = 1'b0; repeat (3) tick(); n_start = 1'b1;
      wait_state(SInput, 100);
      sw = spf_ref(m_que); n_enter = 1'b0;
      repeat (3) tick();
      check("correct_state", int'(STATE), int'(SCorr));
      check("correct_score", int'(SCORE), 1);
      n_enter = 1'b1;

      // Round 2: correct ENTER landing on the final INPUT cycle.
      wait_state(SInput, 100);
      sw = spf_ref(m_que);
      repeat (29) tick();
      n_enter = 1'b0;
      repeat (3) tick();
      check("expiry_enter_state", int'(STATE), int'(SCorr));
      check("expiry_enter_score", int'(SCORE), 2);
      n_enter = 1'b1;

      // Round 3: correct, then reset while showing CORRECT.
      wait_state(SInput, 100);
      sw = spf_ref(m_que); n_enter = 1'b0;
      repeat (3) tick();
      check("r3_state", int'(STATE), int'(SCorr));
      check("r3_score", int'(SCORE), 3);
      n_enter = 1'b1;
      tick();
      n_rst = 1'b0;
      tick();
      check("rst_corr_state", int'(STATE), int'(SIdle));
      check("rst_corr_que", int'(QUE), 0);
      check("rst_corr_din", int'(DIN), 0);
      check("rst_corr_score", int'(SCORE), 0);
      check("rst_corr_round", int'(ROUND), 0);
      check("rst_corr_busy", int'(BUSY), 0);
      n_rst = 1'b1;
      repeat (2) tick();

      // ---------------- randomized phase ----------------
      for (int i = 0; i < 4000; i++) begin
         n_rst = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 9) == 0) n_start = ~n_start;
         if ($urandom_range(0, 5) == 0) n_enter = ~n_enter;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       sw = 4'($urandom_range(0, 15));
               3:       sw = (m_que == 4'd4) ? 4'd9 : 4'($urandom_range(0, 15));
               default: sw = spf_ref(m_que);
            endcase
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
